fwd_hazard_unit: RTL
====================

Name: fwd_hazard_unit

Overview:
- Parametrised successor to the pipeline forwarding logic, for the five-stage core plus long-latency units (mul/div, slow loads).
- Combinationally selects operand bypass sources from NUM_FWD downstream stages, nearest-first.
- Holds a per-register pending scoreboard for out-of-pipe writebacks and raises stall for load-use and scoreboard hazards.
- Sits beside the ID/EX register; its outputs drive the EX operand muxes and the IF/ID hold/bubble control.

Parameters:
- REG_AW, 5: register address width; register count is 2**REG_AW.
- NUM_FWD, 2: number of forwarding stages; index 0 is nearest EX (EX/MEM), index 1 is MEM/WB, and so on.
- MAX_PEND, 4: maximum number of long-latency writes outstanding at once.
- SEL_W, $clog2(NUM_FWD+1): width of the forward select outputs.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- rs1, rs2  in  REG_AW each  source registers of the instruction in EX
- id_rs1, id_rs2  in  REG_AW each  source registers of the instruction in ID
- id_rs1_used, id_rs2_used  in  1 each  ID instruction actually reads that source
- idex_rd  in  REG_AW  destination register of the instruction in EX
- idex_mem_read  in  1  instruction in EX is a load
- fwd_rd  in  NUM_FWD*REG_AW  flattened stage destinations; stage k occupies bits [k*REG_AW +: REG_AW]
- fwd_we  in  NUM_FWD  per-stage register-write enable
- issue_valid  in  1  long-latency op requests issue
- issue_rd  in  REG_AW  destination of the long-latency op
- issue_ready  out  1  issue accepted when issue_valid && issue_ready
- done_valid  in  1  long-latency op writes back this cycle
- done_rd  in  REG_AW  writeback destination
- forwardA, forwardB  out  SEL_W each  0 = register file; k+1 = stage k
- stall  out  1  hold PC and IF/ID, inject bubble into ID/EX
- pend_cnt  out  $clog2(MAX_PEND+1)  number of outstanding long-latency ops
- sb_err  out  1  sticky: done_valid seen for a register that is not pending
- stall_cycles  out  CNT_W  saturating count of cycles with stall high

Behaviour:
- Forwarding (combinational):
  - forwardA is k+1 for the lowest k with fwd_we[k], fwd_rd_k != 0 and fwd_rd_k == rs1; otherwise 0.
  - forwardB uses the same rule against rs2.
  - x0 is never forwarded.
- Scoreboard state: pend[2**REG_AW-1:0] and pend_cnt. pend[0] is never set.
- Issue handshake:
  - issue_ready = (pend_cnt < MAX_PEND) && !pend[issue_rd], which also blocks WAW.
  - issue_rd == 0 is accepted and counted, but sets no pend bit.
- Acceptance sets pend[issue_rd] at the next clock edge.
- done_valid clears pend[done_rd] at the next clock edge and decrements pend_cnt.
  - If pend[done_rd] == 0, pend and pend_cnt are unchanged and sb_err is set (sticky until reset).
  - Note that pend_cnt counts ops while pend only tracks destinations, so an accepted issue to x0 that is later "done" is not pending. A done for x0 therefore sets sb_err and leaves pend_cnt unchanged.
- Same-cycle issue and done:
  - Different rd: both apply; pend_cnt is unchanged.
  - Same rd: not possible, because issue_ready was low while that rd was pending.
- stall = load_use || sb_hit.
  - load_use = idex_mem_read && idex_rd != 0 && ((id_rs1_used && idex_rd == id_rs1) || (id_rs2_used && idex_rd == id_rs2)).
  - sb_hit: a used ID source is nonzero and pend[src] is set, unless done_valid && done_rd == src in the same cycle. The register file is write-first, so that case does not stall.
- stall_cycles increments on every cycle with stall high and saturates at all-ones.
- Latency: forwarding and stall are zero-cycle combinational. Scoreboard updates are visible one cycle after the event.
- Reset (asynchronous, rst_n low):
  - pend, pend_cnt, sb_err and stall_cycles go to 0.
  - forwardA, forwardB, stall and issue_ready follow the now-cleared state; issue_ready = 1.
  - Reset mid-operation discards all in-flight tracking; the core is reset together with this block.

Decomposition:
- Shared package (core_pkg):
  - REG_AW
  - forward-select encodings FWD_RF = 0, FWD_STG_BASE = 1
  - default NUM_FWD and MAX_PEND
- One natural sub-module, reg_scoreboard: owns pend, pend_cnt, sb_err, the issue handshake and the done bypass query.
- The top level keeps the priority forwarding mux, the load-use check and the stall counter.

Test Plan:
1. Forward priority: rs1 = 5, fwd_rd = {5, 5}, fwd_we = 2'b11 -> forwardA = 1. With fwd_we = 2'b10 -> forwardA = 2. With rs1 = 0 -> forwardA = 0.
2. Load-use: idex_mem_read = 1, idex_rd = 7, id_rs2 = 7, id_rs2_used = 1 -> stall = 1. With id_rs2_used = 0 -> stall = 0.
3. Scoreboard: issue rd = 9, then ID reads x9 -> stall = 1 each cycle. done rd = 9 arrives -> stall = 0 that same cycle; pend_cnt goes 1 -> 0.
4. Full and WAW: issue 4 distinct rds -> pend_cnt = 4, issue_ready = 0. Complete one -> issue_ready = 1. Issue to a pending rd -> issue_ready = 0.
5. Simultaneous issue rd = 3 and done rd = 4 with pend_cnt = 2 -> pend_cnt stays 2, pend[3] = 1, pend[4] = 0.
6. Errors and reset: done rd = 12 while not pending -> sb_err = 1 and stays 1. rst_n low mid-stream -> all outputs return to their reset values immediately; stall_cycles = 0.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared constants for the core's hazard/forwarding logic.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

  // Architectural register address width (32 registers).
  localparam int REG_AW       = 5;

  // Forward-select encodings: 0 selects the register file, BASE+k stage k.
  localparam int FWD_RF       = 0;
  localparam int FWD_STG_BASE = 1;

  // Default pipeline shape.
  localparam int DEF_NUM_FWD  = 2;
  localparam int DEF_MAX_PEND = 4;

endpackage : core_pkg
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register pending tracker for long-latency writebacks.
//               Owns the issue handshake, outstanding-op count, sticky error
//               flag and the ID-stage hazard query with writeback bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard import core_pkg::*; #(
  parameter int REG_AW   = core_pkg::REG_AW,
  parameter int MAX_PEND = DEF_MAX_PEND,
  parameter int CW       = $clog2(MAX_PEND + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  output logic              issue_ready,
  input  logic              done_valid,
  input  logic [REG_AW-1:0] done_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  output logic              sb_hit,
  output logic [CW-1:0]     pend_cnt,
  output logic              sb_err
);

  localparam int NREG = 2 ** REG_AW;

  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_nxt;
  logic            issue_fire;
  logic            done_hit;
  logic            done_bad;
  logic            rs1_hit;
  logic            rs2_hit;

  // A pending destination blocks re-issue, which also rules out WAW.
  assign issue_ready = (pend_cnt < CW'(MAX_PEND)) && !pend[issue_rd];
  assign issue_fire  = issue_valid && issue_ready;
  assign done_hit    = done_valid && pend[done_rd];
  assign done_bad    = done_valid && !pend[done_rd];

  // A source completing this cycle is written first in the register file,
  // so it is not a hazard even though its pend bit is still set.
  assign rs1_hit = id_rs1_used && (id_rs1 != '0) && pend[id_rs1] &&
                   !(done_valid && (done_rd == id_rs1));
  assign rs2_hit = id_rs2_used && (id_rs2 != '0) && pend[id_rs2] &&
                   !(done_valid && (done_rd == id_rs2));
  assign sb_hit  = rs1_hit || rs2_hit;

  // Next pend vector: clear on completion, set on accepted issue, x0 never.
  always_comb begin
    pend_nxt = pend;
    if (done_hit) begin
      pend_nxt[done_rd] = 1'b0;
    end
    if (issue_fire && (issue_rd != '0)) begin
      pend_nxt[issue_rd] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  // Scoreboard state: pend bits, op count and sticky unexpected-done flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      pend_cnt <= '0;
      sb_err   <= 1'b0;
    end else begin
      pend <= pend_nxt;
      case ({issue_fire, done_hit})
        2'b10:   pend_cnt <= pend_cnt + 1'b1;
        2'b01:   pend_cnt <= pend_cnt - 1'b1;
        default: pend_cnt <= pend_cnt;
      endcase
      if (done_bad) begin
        sb_err <= 1'b1;
      end
    end
  end

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_unit
// Description : Operand forwarding select (nearest stage first), load-use
//               and scoreboard stall generation, and stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit import core_pkg::*; #(
  parameter int REG_AW   = core_pkg::REG_AW,
  parameter int NUM_FWD  = DEF_NUM_FWD,
  parameter int MAX_PEND = DEF_MAX_PEND,
  parameter int SEL_W    = $clog2(NUM_FWD + 1),
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_AW-1:0]         rs1,
  input  logic [REG_AW-1:0]         rs2,
  input  logic [REG_AW-1:0]         id_rs1,
  input  logic [REG_AW-1:0]         id_rs2,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic [REG_AW-1:0]         idex_rd,
  input  logic                      idex_mem_read,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic                      issue_valid,
  input  logic [REG_AW-1:0]         issue_rd,
  output logic                      issue_ready,
  input  logic                      done_valid,
  input  logic [REG_AW-1:0]         done_rd,
  output logic [SEL_W-1:0]          forwardA,
  output logic [SEL_W-1:0]          forwardB,
  output logic                      stall,
  output logic [$clog2(MAX_PEND+1)-1:0] pend_cnt,
  output logic                      sb_err,
  output logic [CNT_W-1:0]          stall_cycles
);

  logic [REG_AW-1:0] stg_rd [NUM_FWD];
  logic              load_use;
  logic              sb_hit;

  for (genvar k = 0; k < NUM_FWD; k++) begin : g_unpack
    assign stg_rd[k] = fwd_rd[k*REG_AW +: REG_AW];
  end

  // Priority forward select: scan farthest to nearest so the nearest match wins.
  always_comb begin
    forwardA = SEL_W'(FWD_RF);
    forwardB = SEL_W'(FWD_RF);
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_we[k] && (stg_rd[k] != '0) && (stg_rd[k] == rs1)) begin
        forwardA = SEL_W'(FWD_STG_BASE + k);
      end
      if (fwd_we[k] && (stg_rd[k] != '0) && (stg_rd[k] == rs2)) begin
        forwardB = SEL_W'(FWD_STG_BASE + k);
      end
    end
  end

  // A load in EX cannot forward to the very next instruction.
  assign load_use = idex_mem_read && (idex_rd != '0) &&
                    ((id_rs1_used && (idex_rd == id_rs1)) ||
                     (id_rs2_used && (idex_rd == id_rs2)));

  assign stall = load_use || sb_hit;

  reg_scoreboard #(
    .REG_AW   (REG_AW),
    .MAX_PEND (MAX_PEND),
    .CW       ($clog2(MAX_PEND + 1))
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .done_valid  (done_valid),
    .done_rd     (done_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .sb_hit      (sb_hit),
    .pend_cnt    (pend_cnt),
    .sb_err      (sb_err)
  );

  // Saturating count of stalled cycles for performance monitoring.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule : fwd_hazard_unit
`default_nettype wire
